cmul_sequencer: RTL and testbench



---
 rtl/cmul_pkg.sv | 23 ++
 rtl/cmul_sequencer_sm_add.sv | 40 ++++
 rtl/fixed_point_math.sv | 21 ++
 rtl/cmul_sequencer.sv | 164 ++++++++++++++++
 tb/tb_cmul_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cmul_pkg.sv
// cmul_pkg: shared types and constants for the complex twiddle multiplier.
//   - cmul_state_e : sequencer FSM states
//   - FRAC_BITS, WIDTH, MAG_MAX : Q7.8 sign-magnitude format constants
//   - UNITY_RE / UNITY_IM : the twiddle w = 1 + 0j
package cmul_pkg;

    localparam int          FRAC_BITS = 8;
    localparam int          WIDTH     = 16;
    localparam logic [14:0] MAG_MAX   = 15'h7FFF;

    localparam logic [WIDTH-1:0] UNITY_RE = 16'h0100;
    localparam logic [WIDTH-1:0] UNITY_IM = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL0 = 3'd1,
        ST_MUL1 = 3'd2,
        ST_MUL2 = 3'd3,
        ST_MUL3 = 3'd4,
        ST_DONE = 3'd5
    } cmul_state_e;

endpackage

// File: rtl/cmul_sequencer_sm_add.sv
// sm_add: combinational sign-magnitude add/subtract with saturation.
//   x, y : Q7.8 sign-magnitude operands
//   sub  : 1 -> z = x - y, 0 -> z = x + y
//   z    : result; magnitude saturates to MAG_MAX, never emits -0
module sm_add
    import cmul_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] z
);

    logic        xs;
    logic        ys;
    logic [15:0] sum;
    logic [14:0] mag;
    logic        sgn;

    always_comb begin
        xs  = x[15];
        ys  = y[15] ^ sub;
        sum = {1'b0, x[14:0]} + {1'b0, y[14:0]};
        mag = '0;
        sgn = 1'b0;
        if (xs == ys) begin
            // Carry out of bit 14 means the magnitude overflowed.
            mag = sum[15] ? MAG_MAX : sum[14:0];
            sgn = xs;
        end else if (x[14:0] >= y[14:0]) begin
            mag = x[14:0] - y[14:0];
            sgn = xs;
        end else begin
            mag = y[14:0] - x[14:0];
            sgn = ys;
        end
        z = (mag == 15'd0) ? 16'h0000 : {sgn, mag};
    end

endmodule

// File: rtl/fixed_point_math.sv
// fixed_point_math: combinational Q7.8 sign-magnitude multiplier.
//   a, b : operands (bit 15 sign, 14:8 integer, 7:0 fraction)
//   prod : product; sign = XOR of signs, magnitude = bits [22:8] of the
//          30-bit magnitude product (truncated, no rounding/saturation).
//          A zero magnitude may carry a set sign bit; consumers normalise.
module fixed_point_math
    import cmul_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] prod
);

    logic [29:0] mag_prod;
    logic [14:0] mag_trunc;

    assign mag_prod  = a[14:0] * b[14:0];
    assign mag_trunc = 15'(mag_prod >> FRAC_BITS);
    assign prod      = {a[15] ^ b[15], mag_trunc};

endmodule

// File: rtl/cmul_sequencer.sv
// cmul_sequencer: one complex multiply y = a * w per transaction, using a
// single shared Q7.8 sign-magnitude multiplier over four FSM cycles.
//   clk, n_rst          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a_re, a_im, w_re, w_im)
//   out_valid/out_ready : result handshake (y_re, y_im)
//   dbg_state           : current FSM state (cmul_state_e encoding)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid/data hold until that edge. in_ready is 1 only in IDLE, and
// out_valid only in DONE, so both sides never transfer in the same cycle.
module cmul_sequencer
    import cmul_pkg::*;
#(
    parameter bit SKIP_UNITY = 1'b1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_re,
    input  logic [WIDTH-1:0] a_im,
    input  logic [WIDTH-1:0] w_re,
    input  logic [WIDTH-1:0] w_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y_re,
    output logic [WIDTH-1:0] y_im,
    output logic [2:0]       dbg_state
);

    cmul_state_e      state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] ar_q, ar_d, ai_q, ai_d;
    logic [WIDTH-1:0] wr_q, wr_d, wi_q, wi_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] y_re_q, y_re_d, y_im_q, y_im_d;

    logic [WIDTH-1:0] mul_a, mul_b, mul_p;
    logic [WIDTH-1:0] add_z;
    logic             add_sub;

    fixed_point_math u_mul (
        .a    (mul_a),
        .b    (mul_b),
        .prod (mul_p)
    );

    // Shared adder: partial product from MUL0/MUL2 combined with the
    // product issued in MUL1 (subtract) or MUL3 (add).
    sm_add u_add (
        .x   (p_q),
        .y   (mul_p),
        .sub (add_sub),
        .z   (add_z)
    );

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        ar_d        = ar_q;
        ai_d        = ai_q;
        wr_d        = wr_q;
        wi_d        = wi_q;
        p_d         = p_q;
        y_re_d      = y_re_q;
        y_im_d      = y_im_q;
        mul_a       = '0;
        mul_b       = '0;
        add_sub     = (state_q == ST_MUL1);

        // Multiplier operand routing by state.
        case (state_q)
            ST_MUL0: begin mul_a = ar_q; mul_b = wr_q; end
            ST_MUL1: begin mul_a = ai_q; mul_b = wi_q; end
            ST_MUL2: begin mul_a = ar_q; mul_b = wi_q; end
            ST_MUL3: begin mul_a = ai_q; mul_b = wr_q; end
            default: begin mul_a = '0;   mul_b = '0;   end
        endcase

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ar_d       = a_re;
                    ai_d       = a_im;
                    wr_d       = w_re;
                    wi_d       = w_im;
                    in_ready_d = 1'b0;
                    if (SKIP_UNITY && (w_re == UNITY_RE) && (w_im == UNITY_IM)) begin
                        y_re_d      = a_re;
                        y_im_d      = a_im;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_MUL0;
                    end
                end
            end
            ST_MUL0: begin
                p_d     = mul_p;
                state_d = ST_MUL1;
            end
            ST_MUL1: begin
                y_re_d  = add_z;
                state_d = ST_MUL2;
            end
            ST_MUL2: begin
                p_d     = mul_p;
                state_d = ST_MUL3;
            end
            ST_MUL3: begin
                y_im_d      = add_z;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ar_q        <= '0;
            ai_q        <= '0;
            wr_q        <= '0;
            wi_q        <= '0;
            p_q         <= '0;
            y_re_q      <= '0;
            y_im_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            ar_q        <= ar_d;
            ai_q        <= ai_d;
            wr_q        <= wr_d;
            wi_q        <= wi_d;
            p_q         <= p_d;
            y_re_q      <= y_re_d;
            y_im_q      <= y_im_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y_re      = y_re_q;
    assign y_im      = y_im_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cmul_sequencer.sv
module tb_cmul_sequencer;

    logic        clk;
    logic        n_rst;
    logic        in_valid, in_ready;
    logic [15:0] a_re, a_im, w_re, w_im;
    logic        out_valid, out_ready;
    logic [15:0] y_re, y_im;
    logic [2:0]  dbg_state;

    logic        in_valid_nu, in_ready_nu;
    logic        out_valid_nu, out_ready_nu;
    logic [15:0] y_re_nu, y_im_nu;
    logic [2:0]  dbg_state_nu;

    int n_tests;
    int n_fail;

    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    cmul_sequencer #(.SKIP_UNITY(1'b1)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_re      (a_re),
        .a_im      (a_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_re      (y_re),
        .y_im      (y_im),
        .dbg_state (dbg_state)
    );

    cmul_sequencer #(.SKIP_UNITY(1'b0)) dut_nu (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid_nu),
        .in_ready  (in_ready_nu),
        .a_re      (a_re),
        .a_im      (a_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .out_valid (out_valid_nu),
        .out_ready (out_ready_nu),
        .y_re      (y_re_nu),
        .y_im      (y_im_nu),
        .dbg_state (dbg_state_nu)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Presents operands for one edge; returns at the negedge of cycle 1.
    task automatic drive(input logic [15:0] ar, input logic [15:0] ai,
                         input logic [15:0] wr, input logic [15:0] wi);
        a_re     = ar;
        a_im     = ai;
        w_re     = wr;
        w_im     = wi;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for out_valid, checks latency and data against the scoreboard.
    task automatic collect(input string tag, input int exp_lat);
        int lat = 1;
        logic [31:0] e;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_qsize"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_y_re"}, {16'd0, y_re}, {16'd0, e[31:16]});
            check({tag, "_y_im"}, {16'd0, y_im}, {16'd0, e[15:0]});
        end
        check({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic run_txn(input string tag,
                           input logic [15:0] ar, input logic [15:0] ai,
                           input logic [15:0] wr, input logic [15:0] wi,
                           input logic [15:0] er, input logic [15:0] ei,
                           input int lat);
        exp_q.push_back({er, ei});
        out_ready = 1'b1;
        wait_ready(tag);
        drive(ar, ai, wr, wi);
        collect(tag, lat);
        @(negedge clk);
        check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        n_tests      = 0;
        n_fail       = 0;
        n_rst        = 1'b0;
        in_valid     = 1'b0;
        in_valid_nu  = 1'b0;
        out_ready    = 1'b1;
        out_ready_nu = 1'b1;
        a_re = '0; a_im = '0; w_re = '0; w_im = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y_re",      {16'd0, y_re}, 32'd0);
        check("rst_y_im",      {16'd0, y_im}, 32'd0);
        check("rst_state",     {29'd0, dbg_state}, 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // Real-axis a, non-unity w: 1 * (0.5 + 0.5j).
        run_txn("real_axis", 16'h0100, 16'h0000, 16'h0080, 16'h0080, 16'h0080, 16'h0080, 5);
        // Mixed signs: (2 + 1j) * (0.5 - 0.5j) = 1.5 - 0.5j.
        run_txn("mixed",     16'h0200, 16'h0100, 16'h0080, 16'h8080, 16'h0180, 16'h8080, 5);
        // Saturation on re, exact cancellation on im (must be +0).
        run_txn("sat_zero",  16'h7F00, 16'h7F00, 16'h0100, 16'h8100, 16'h7FFF, 16'h0000, 5);
        // Unity bypass.
        run_txn("unity",     16'h1234, 16'h8567, 16'h0100, 16'h0000, 16'h1234, 16'h8567, 1);
        // Conjugate-style twiddle: (1 + 2j) * (0 - 1j) = 2 - 1j.
        run_txn("neg_j",     16'h0100, 16'h0200, 16'h0000, 16'h8100, 16'h0200, 16'h8100, 5);

        // Unity operands on the instance without bypass: full latency.
        a_re = 16'h1234; a_im = 16'h8567; w_re = 16'h0100; w_im = 16'h0000;
        in_valid_nu = 1'b1;
        @(negedge clk);
        in_valid_nu = 1'b0;
        lat = 1;
        while (!out_valid_nu && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("nounity_lat",  lat, 5);
        check("nounity_y_re", {16'd0, y_re_nu}, 32'h0000_1234);
        check("nounity_y_im", {16'd0, y_im_nu}, 32'h0000_8567);
        @(negedge clk);

        // Backpressure: result held while a new request waits.
        exp_q.push_back(32'h0180_8080);
        out_ready = 1'b0;
        wait_ready("bp1");
        drive(16'h0200, 16'h0100, 16'h0080, 16'h8080);
        collect("bp1", 5);
        a_re = 16'h0100; a_im = 16'h0000; w_re = 16'h0080; w_im = 16'h0080;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold_y",     {y_re, y_im}, 32'h0180_8080);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_back_idle_ready", {31'd0, in_ready}, 32'd1);
        check("bp_back_idle_valid", {31'd0, out_valid}, 32'd0);
        exp_q.push_back(32'h0080_0080);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp2_accepted", {31'd0, in_ready}, 32'd0);
        collect("bp2", 5);
        @(negedge clk);

        // Reset asserted during MUL2 aborts the transaction.
        out_ready = 1'b1;
        wait_ready("rstmid");
        drive(16'h0200, 16'h0100, 16'h0080, 16'h8080);
        @(negedge clk);
        @(negedge clk);
        check("rstmid_in_mul2", {29'd0, dbg_state}, 32'd3);
        n_rst = 1'b0;
        #1;
        check("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rstmid_in_ready",  {31'd0, in_ready}, 32'd1);
        check("rstmid_y",         {y_re, y_im}, 32'd0);
        check("rstmid_state",     {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
        run_txn("post_rst", 16'h0200, 16'h0100, 16'h0080, 16'h8080, 16'h0180, 16'h8080, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
